// File: rtl/arcade_input_ctrl_if.sv
// Signal bundle between hps_io and the arcade input stage: keyboard event
// word and joystick word in, the registered active-low button byte out.
interface arcade_input_ctrl_if;
    logic [10:0] ps2_key;
    logic [15:0] joy;
    logic [7:0]  btn_n;

    modport master (output ps2_key, output joy, input btn_n);
    modport slave  (input ps2_key, input joy, output btn_n);
endinterface

// File: rtl/arcade_input_ctrl.sv
// Keyboard/joystick to active-low button byte for the vector arcade core.
// Define INPUT_COIN_STRETCH_EN to build the debounced coin pulse stretcher.
module arcade_input_ctrl #(
    parameter int COIN_PULSE = 2500000,
    parameter int COIN_GAP   = 250000
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    arcade_input_ctrl_if.slave   io
);
    localparam int CMAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    logic        tog_q, primed;
    logic [15:0] flag, hit;
    logic [15:0] joy_q;
    logic [7:0]  fn;
    logic        coin_src, coin_out, event_now;
    logic [7:0]  code_lo;

    assign code_lo   = io.ps2_key[7:0];
    assign event_now = primed && (io.ps2_key[10] != tog_q);

    // One flag per physical key; extended-insensitive codes compare bits [7:0] only.
    always_comb begin
        hit     = '0;
        hit[0]  = code_lo == 8'h74;
        hit[1]  = io.ps2_key[8:0] == 9'h023;
        hit[2]  = code_lo == 8'h6B;
        hit[3]  = io.ps2_key[8:0] == 9'h01C;
        hit[4]  = io.ps2_key[8:0] == 9'h005;
        hit[5]  = io.ps2_key[8:0] == 9'h016;
        hit[6]  = io.ps2_key[8:0] == 9'h006;
        hit[7]  = io.ps2_key[8:0] == 9'h03A;
        hit[8]  = io.ps2_key[8:0] == 9'h014;
        hit[9]  = io.ps2_key[8:0] == 9'h004;
        hit[10] = io.ps2_key[8:0] == 9'h02E;
        hit[11] = io.ps2_key[8:0] == 9'h036;
        hit[12] = io.ps2_key[8:0] == 9'h04B;
        hit[13] = io.ps2_key[8:0] == 9'h011;
        hit[14] = io.ps2_key[8:0] == 9'h042;
        hit[15] = io.ps2_key[8:0] == 9'h029;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tog_q  <= 1'b0;
            primed <= 1'b0;
            flag   <= '0;
            joy_q  <= '0;
        end else begin
            primed <= 1'b1;
            tog_q  <= io.ps2_key[10];
            joy_q  <= io.joy;
            if (event_now)
                flag <= (flag & ~hit) | (hit & {16{io.ps2_key[9]}});
        end
    end

    // fn bit positions match btn_n: {right,left,start1,start2,fire,coin,thrust,shield}
    always_comb begin
        fn       = '0;
        fn[7]    = flag[0]  | flag[1]  | joy_q[0];
        fn[6]    = flag[2]  | flag[3]  | joy_q[1];
        fn[5]    = flag[4]  | flag[5]  | joy_q[7];
        fn[4]    = flag[6];
        fn[3]    = flag[7]  | flag[8]  | joy_q[4];
        fn[1]    = flag[12] | flag[13] | joy_q[5];
        fn[0]    = flag[14] | flag[15] | joy_q[6];
        coin_src = flag[9]  | flag[10] | flag[11] | joy_q[8];
    end

    wire joy_unused = &{1'b0, joy_q[15:9], joy_q[3:2]};

`ifdef INPUT_COIN_STRETCH_EN
    typedef enum logic [1:0] {IDLE, PULSE, HOLD} coin_state_t;
    localparam logic [CW-1:0] PULSE_LD = CW'(COIN_PULSE - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(COIN_GAP - 1);

    coin_state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic coin_prev;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            coin_prev <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            coin_prev <= coin_src;
        end
    end

    // HOLD re-arms only after COIN_GAP consecutive released cycles.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (coin_src && !coin_prev) begin
                state_nx = PULSE;
                cnt_nx   = PULSE_LD;
            end
            PULSE: if (cnt == '0) begin
                state_nx = HOLD;
                cnt_nx   = GAP_LD;
            end else begin
                cnt_nx = cnt - 1'b1;
            end
            HOLD: if (coin_src) begin
                cnt_nx = GAP_LD;
            end else if (cnt == '0) begin
                state_nx = IDLE;
            end else begin
                cnt_nx = cnt - 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign coin_out = (state == PULSE);
`else
    wire cfg_unused = (CW > 0) && (COIN_PULSE > 0) && (COIN_GAP > 0);
    assign coin_out = coin_src;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) io.btn_n <= 8'hFF;
        else       io.btn_n <= ~{fn[7:3], coin_out, fn[1:0]};
    end
endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Self-checking bench for arcade_input_ctrl: vector table, coin/reset
// sequences and randomized traffic against a key-map reference model.
module tb_arcade_input_ctrl;
    localparam int P = 4;
    localparam int G = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    arcade_input_ctrl_if io();
    arcade_input_ctrl #(.COIN_PULSE(P), .COIN_GAP(G)) dut (
        .clk_sys(clk), .reset(reset), .io(io)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    int kfn [16] = '{7, 7, 6, 6, 5, 5, 4, 3, 3, 2, 2, 2, 1, 1, 0, 0};
    bit held [16];
    logic [15:0] mjoy;
    bit mprimed, mtog, mprev, holding;
    int pulse_rem, zero_run;
    logic [7:0] mbtn;

    function automatic int key_id(input logic [8:0] c);
        case (c)
            9'h074, 9'h174: return 0;
            9'h023:         return 1;
            9'h06B, 9'h16B: return 2;
            9'h01C:         return 3;
            9'h005:         return 4;
            9'h016:         return 5;
            9'h006:         return 6;
            9'h03A:         return 7;
            9'h014:         return 8;
            9'h004:         return 9;
            9'h02E:         return 10;
            9'h036:         return 11;
            9'h04B:         return 12;
            9'h011:         return 13;
            9'h042:         return 14;
            9'h029:         return 15;
            default:        return -1;
        endcase
    endfunction

    function automatic logic [7:0] fvec();
        logic [7:0] f;
        f = '0;
        for (int i = 0; i < 16; i++) if (held[i]) f[kfn[i]] = 1'b1;
        f[7] |= mjoy[0]; f[6] |= mjoy[1]; f[5] |= mjoy[7]; f[3] |= mjoy[4];
        f[2] |= mjoy[8]; f[1] |= mjoy[5]; f[0] |= mjoy[6];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) held[i] = 1'b0;
        mjoy = '0; mprimed = 0; mtog = 0; mprev = 0; holding = 0;
        pulse_rem = 0; zero_run = 0; mbtn = 8'hFF;
    endtask

    task automatic model_edge();
        logic [7:0] f;
        bit src;
        int k;
        f = fvec();
        src = f[2];
`ifdef INPUT_COIN_STRETCH_EN
        f[2] = (pulse_rem > 0);
        if (pulse_rem > 0) begin
            pulse_rem--;
            if (pulse_rem == 0) begin holding = 1; zero_run = 0; end
        end else if (holding) begin
            zero_run = src ? 0 : zero_run + 1;
            if (zero_run >= G) holding = 0;
        end else if (src && !mprev) begin
            pulse_rem = P;
        end
        mprev = src;
`endif
        mbtn = ~f;
        mjoy = io.joy;
        if (mprimed && io.ps2_key[10] != mtog) begin
            k = key_id(io.ps2_key[8:0]);
            if (k >= 0) held[k] = io.ps2_key[9];
        end
        mtog = io.ps2_key[10];
        mprimed = 1;
    endtask

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        if (reset) model_reset(); else model_edge();
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [8:0] code, input logic pr);
        io.ps2_key = {~io.ps2_key[10], pr, code};
    endtask

    int lows, falls;
    logic lastc;
    task automatic count_steps(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            if (io.btn_n[2] == 1'b0) lows++;
            if (lastc && !io.btn_n[2]) falls++;
            lastc = io.btn_n[2];
        end
    endtask

    typedef struct {
        bit          ev;
        logic [8:0]  code;
        bit          pr;
        logic [15:0] joy;
        logic [7:0]  exp;
    } vec_t;
    vec_t tbl[$];

    logic [8:0] pool [20] = '{9'h074, 9'h174, 9'h023, 9'h06B, 9'h16B, 9'h01C, 9'h005,
                              9'h016, 9'h006, 9'h03A, 9'h014, 9'h004, 9'h02E, 9'h036,
                              9'h04B, 9'h011, 9'h042, 9'h029, 9'h123, 9'h105};

    initial begin
        tbl.push_back('{1'b1, 9'h16B, 1'b1, 16'h0000, 8'hBF});
        tbl.push_back('{1'b1, 9'h06B, 1'b0, 16'h0000, 8'hFF});
        tbl.push_back('{1'b1, 9'h029, 1'b1, 16'h0000, 8'hFE});
        tbl.push_back('{1'b0, 9'h000, 1'b0, 16'h0011, 8'h76});
        tbl.push_back('{1'b0, 9'h000, 1'b0, 16'h0000, 8'hFE});
        tbl.push_back('{1'b1, 9'h029, 1'b0, 16'h0000, 8'hFF});
        tbl.push_back('{1'b1, 9'h123, 1'b1, 16'h0000, 8'hFF});
        tbl.push_back('{1'b1, 9'h174, 1'b1, 16'h0000, 8'h7F});
        tbl.push_back('{1'b1, 9'h074, 1'b0, 16'h0000, 8'hFF});
        tbl.push_back('{1'b1, 9'h023, 1'b1, 16'h0000, 8'h7F});
        tbl.push_back('{1'b1, 9'h023, 1'b0, 16'h0000, 8'hFF});
        tbl.push_back('{1'b1, 9'h016, 1'b1, 16'h0000, 8'hDF});
        tbl.push_back('{1'b1, 9'h005, 1'b1, 16'h0000, 8'hDF});
        tbl.push_back('{1'b1, 9'h016, 1'b0, 16'h0000, 8'hDF});
        tbl.push_back('{1'b1, 9'h005, 1'b0, 16'h0000, 8'hFF});
        tbl.push_back('{1'b1, 9'h006, 1'b1, 16'h00E2, 8'h8C});
        tbl.push_back('{1'b1, 9'h006, 1'b0, 16'h0000, 8'hFF});
        tbl.push_back('{1'b1, 9'h03A, 1'b1, 16'h0000, 8'hF7});
        tbl.push_back('{1'b1, 9'h014, 1'b0, 16'h0000, 8'hF7});
        tbl.push_back('{1'b1, 9'h03A, 1'b0, 16'h0000, 8'hFF});
        tbl.push_back('{1'b1, 9'h04B, 1'b1, 16'h0000, 8'hFD});
        tbl.push_back('{1'b1, 9'h011, 1'b1, 16'h0000, 8'hFD});
        tbl.push_back('{1'b1, 9'h04B, 1'b0, 16'h0000, 8'hFD});
        tbl.push_back('{1'b1, 9'h011, 1'b0, 16'h0000, 8'hFF});
        tbl.push_back('{1'b1, 9'h01C, 1'b1, 16'h0002, 8'hBF});
        tbl.push_back('{1'b1, 9'h01C, 1'b0, 16'h0000, 8'hFF});
        tbl.push_back('{1'b1, 9'h042, 1'b1, 16'h0000, 8'hFE});
        tbl.push_back('{1'b1, 9'h042, 1'b0, 16'h0000, 8'hFF});
        tbl.push_back('{1'b0, 9'h000, 1'b0, 16'hFE0C, 8'hFF});
        tbl.push_back('{1'b0, 9'h000, 1'b0, 16'h0000, 8'hFF});

        // Reset with the toggle bit already high: no phantom event afterwards.
        io.ps2_key = 11'h400;
        io.joy     = '0;
        model_reset();
        steps(2);
        check8("reset_state", io.btn_n, 8'hFF);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check8("no_phantom", io.btn_n, 8'hFF);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].ev) send(tbl[i].code, tbl[i].pr);
            io.joy = tbl[i].joy;
            step();
            if (i == 0) check8("latency_one_edge", io.btn_n, 8'hFF);
            step();
            check8($sformatf("vec%0d", i), io.btn_n, tbl[i].exp);
        end

`ifdef INPUT_COIN_STRETCH_EN
        io.joy = 16'h0100; lows = 0; falls = 0; lastc = 1'b1;
        count_steps(10);
        io.joy = 16'h0000;
        count_steps(2);
        check_int("coin_pulse_width", lows, P);
        check_int("coin_pulse_count", falls, 1);
        io.joy = 16'h0100; lows = 0; falls = 0;
        count_steps(6);
        check_int("coin_short_gap", lows, 0);
        io.joy = 16'h0000;
        count_steps(3);
        io.joy = 16'h0100;
        count_steps(10);
        check_int("coin_rearm_width", lows, P);
        check_int("coin_rearm_count", falls, 1);
        io.joy = 16'h0000;
        steps(6);
`else
        send(9'h02E, 1'b1); steps(2); check8("coin_2E", io.btn_n, 8'hFB);
        send(9'h036, 1'b1); steps(2); check8("coin_36", io.btn_n, 8'hFB);
        send(9'h036, 1'b0); steps(2); check8("coin_36_rel", io.btn_n, 8'hFB);
        send(9'h02E, 1'b0); steps(2); check8("coin_2E_rel", io.btn_n, 8'hFF);
`endif

        // Asynchronous reset while the coin output is active.
        send(9'h02E, 1'b1);
        for (int w = 0; w < 10 && io.btn_n[2] !== 1'b0; w++) step();
        check_int("coin_low_before_reset", int'(io.btn_n[2]), 0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check8("reset_async", io.btn_n, 8'hFF);
        steps(2);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check8("post_reset_idle", io.btn_n, 8'hFF);
        end
        send(9'h02E, 1'b0);
        steps(3);
        send(9'h02E, 1'b1);
`ifdef INPUT_COIN_STRETCH_EN
        lows = 0; falls = 0; lastc = 1'b1;
        count_steps(8);
        check_int("post_reset_repress", lows, P);
`else
        steps(2);
        check8("post_reset_repress", io.btn_n, 8'hFB);
`endif
        send(9'h02E, 1'b0);
        steps(8);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0)
                send(($urandom_range(0, 4) == 0) ? 9'($urandom) : pool[$urandom_range(0, 19)],
                     1'($urandom));
            if ($urandom_range(0, 3) == 0)
                io.joy = 16'($urandom) & 16'($urandom) & 16'($urandom);
            step();
            check8("random", io.btn_n, mbtn);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
